wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Writeback-stage register file for the 16-bit datapath.
- Consumes the 16-bit writeback value chosen by the 7-input writeback-select mux and commits it to one of 16 architectural registers.
- Provides two operand read ports to the ALU/operand muxes and one debug read port.
- Register 0 reads as zero; register SP_IDX resets to SP_INIT.

Parameters:
- WIDTH, 16, data width of every register and port.
- NREG, 16, number of registers; the address width is log2(NREG) = 4.
- SP_IDX, 15, index of the stack-pointer register.
- SP_INIT, 16'h7FFE, reset value of register SP_IDX.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- WE  input  1  write enable for the writeback port.
- WA  input  4  write address.
- WD  input  16  write data; driven by the writeback-select mux output.
- RA1  input  4  read address, port 1.
- RA2  input  4  read address, port 2.
- RAD  input  4  debug read address.
- RD1  output  16  read data, port 1.
- RD2  output  16  read data, port 2.
- RDD  output  16  debug read data; no bypass.
- WR_ZERO  output  1  sticky flag, set when a write targets register 0.
- WCOUNT  output  16  count of committed writes, excluding writes to register 0.

Behaviour:
- Reset, taking effect at the edge where RST_N = 0:
  - All registers go to 0, except register SP_IDX, which goes to SP_INIT.
  - WR_ZERO = 0, WCOUNT = 0.
  - Any WE asserted in that same cycle is ignored.
  - Reset mid-stream discards pending state; there is no partial commit.
- Write, at the rising edge with RST_N = 1 and WE = 1:
  - If WA != 0: reg[WA] <= WD; WCOUNT <= WCOUNT + 1.
  - WCOUNT wraps 16'hFFFF -> 16'h0000 with no flag.
  - If WA == 0: no register changes, WCOUNT is unchanged, and WR_ZERO <= 1.
  - WR_ZERO stays 1 until the next reset.
- Write latency: a value is architecturally visible on RDD one cycle after the write edge.
- Read ports RD1/RD2 are combinational in their addresses and the register contents.
- Read of register 0 always returns 16'h0000.
- Write-through bypass on RD1/RD2:
  - If WE = 1, WA != 0 and RAx == WA in the same cycle, RDx = WD, not the stale register value.
  - This gives zero-cycle read-after-write for the next pipeline consumer.
- RDD never bypasses; it always shows the committed register value.
- Simultaneous RA1 == RA2 == WA: both ports return WD.
- Bypass is suppressed while RST_N = 0. During reset, reads return the current pre-reset contents until the reset edge commits.
- No X propagation: all 16 addresses are valid for NREG = 16, and there is no out-of-range case.
- WD is used only when WE = 1; X on WD with WE = 0 must not corrupt any state.

Test Plan:
- Reset values: hold RST_N = 0 for 2 cycles, then release.
  - RAD = 15 -> RDD = 16'h7FFE.
  - RAD = 3 -> RDD = 16'h0000.
  - WR_ZERO = 0, WCOUNT = 0.
- Write/read-back: WE = 1, WA = 5, WD = 16'hBEEF for one cycle, then WE = 0.
  - Next cycle RA1 = 5 -> RD1 = 16'hBEEF.
  - RDD with RAD = 5 -> 16'hBEEF.
  - WCOUNT = 1.
- Bypass: reg 7 = 16'h1111; in one cycle drive WE = 1, WA = 7, WD = 16'h2222, RA1 = RA2 = 7, RAD = 7.
  - Same cycle: RD1 = RD2 = 16'h2222, RDD = 16'h1111.
  - After the edge: RDD = 16'h2222.
- Register 0: WE = 1, WA = 0, WD = 16'hFFFF.
  - RA1 = 0 -> RD1 = 16'h0000 in the same cycle and after the edge.
  - WR_ZERO = 1 after the edge; WCOUNT unchanged.
- Reset overrides write: RST_N = 0 and WE = 1, WA = 15, WD = 16'h1234 in the same cycle.
  - After the edge: reg 15 = 16'h7FFE, WCOUNT = 0.
- Counter wrap: perform 65536 writes to WA = 2 -> WCOUNT = 16'h0000, reg 2 holds the last WD.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback/read bus of the writeback-stage register file.
//   master : pipeline side; drives WE/WA/WD and the read addresses RA1/RA2/RAD
//   slave  : register file; drives RD1/RD2/RDD, WR_ZERO and WCOUNT
//   WE      write enable          WA/WD     write address / data
//   RA1/RA2 operand read addrs    RD1/RD2   operand read data (bypassed)
//   RAD     debug read address    RDD       debug read data (committed only)
//   WR_ZERO sticky write-to-r0    WCOUNT    committed non-r0 write count
interface wb_regfile_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             WE;
    logic [AW-1:0]    WA;
    logic [WIDTH-1:0] WD;
    logic [AW-1:0]    RA1;
    logic [AW-1:0]    RA2;
    logic [AW-1:0]    RAD;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic [WIDTH-1:0] RDD;
    logic             WR_ZERO;
    logic [WIDTH-1:0] WCOUNT;

    modport master (
        output WE, WA, WD, RA1, RA2, RAD,
        input  RD1, RD2, RDD, WR_ZERO, WCOUNT
    );

    modport slave (
        input  WE, WA, WD, RA1, RA2, RAD,
        output RD1, RD2, RDD, WR_ZERO, WCOUNT
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file, NREG x WIDTH.
//   CLK    clock, all state updates on the rising edge
//   RST_N  synchronous active-low reset; all regs to 0, reg SP_IDX to SP_INIT
//   bus    wb_regfile_if slave modport: one write port, two bypassed operand
//          read ports, one non-bypassed debug read port, WR_ZERO/WCOUNT status
// Register 0 is hard-wired to zero; writes to it only set WR_ZERO.
module wb_regfile #(
    parameter int               WIDTH   = 16,
    parameter int               NREG    = 16,
    parameter int               SP_IDX  = 15,
    parameter logic [WIDTH-1:0] SP_INIT = 16'h7FFE
) (
    input  logic         CLK,
    input  logic         RST_N,
    wb_regfile_if.slave  bus
);
    localparam int          AW   = $clog2(NREG);
    localparam int unsigned SP_U = SP_IDX;

    logic [WIDTH-1:0] r_regs [NREG];
    logic             r_wr_zero;
    logic [WIDTH-1:0] r_wcount;

    logic             w_wr_live;   // a real (non-r0) write is committing this cycle
    logic             w_byp1;
    logic             w_byp2;
    logic [AW-1:0]    w_ra1;
    logic [AW-1:0]    w_ra2;
    logic [AW-1:0]    w_rad;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == SP_U) ? SP_INIT : '0;
            end
            r_wr_zero <= 1'b0;
            r_wcount  <= '0;
        end else if (bus.WE) begin
            if (bus.WA != '0) begin
                r_regs[bus.WA] <= bus.WD;
                r_wcount       <= r_wcount + 1'b1;
            end else begin
                r_wr_zero <= 1'b1;
            end
        end
    end

    // Bypass is qualified by RST_N so reads during reset show pre-reset contents.
    always_comb begin
        w_ra1     = bus.RA1;
        w_ra2     = bus.RA2;
        w_rad     = bus.RAD;
        w_wr_live = RST_N && bus.WE && (bus.WA != '0);
        w_byp1    = w_wr_live && (w_ra1 == bus.WA);
        w_byp2    = w_wr_live && (w_ra2 == bus.WA);
    end

    always_comb begin
        bus.RD1 = '0;
        bus.RD2 = '0;
        bus.RDD = '0;
        if (w_ra1 != '0) bus.RD1 = w_byp1 ? bus.WD : r_regs[w_ra1];
        if (w_ra2 != '0) bus.RD2 = w_byp2 ? bus.WD : r_regs[w_ra2];
        if (w_rad != '0) bus.RDD = r_regs[w_rad];
    end

    assign bus.WR_ZERO = r_wr_zero;
    assign bus.WCOUNT  = r_wcount;
endmodule
